uart_music_tx: RTL and testbench

- Transmit-side counterpart of the UART music receive path.
- On a start request, reads the stored note table (NUM_NOTES entries of 5-bit notes) through a synchronous read port.
- Sends each note as one UART byte, then sends a terminator byte (TERM_BYTE, default 66 = 'B') to tell the host the dump is finished.
- Sits between the note RAM read port and the board uart_tx pin.

---
 rtl/uart_music_pkg.sv | 22 ++
 rtl/uart_music_tx_byte.sv | 82 ++++++++
 rtl/uart_music_tx.sv | 136 +++++++++++++
 tb/tb_uart_music_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_music_pkg.sv
// Shared types and constants for the UART music transmit path.
package uart_music_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      SEND,
      TERM,
      FIN
   } state_e;

   localparam logic [7:0]  TERM_BYTE_DEFAULT = 8'd66;

   localparam int unsigned FRAME_BITS = 10;
   localparam logic        START_BIT  = 1'b0;
   localparam logic        STOP_BIT   = 1'b1;

   localparam int unsigned BAUD_W = 16;
   localparam int unsigned BIT_W  = 4;

endpackage

// File: rtl/uart_music_tx_byte.sv
// 8N1 serialiser: one start bit, 8 data bits LSB first, one stop bit.
module uart_tx_byte
   import uart_music_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] byte_in,
   output logic       tx,
   output logic       tx_done,
   output logic       tx_busy
);

   logic              busy_q,  busy_d;
   logic [BAUD_W-1:0] baud_q,  baud_d;
   logic [BIT_W-1:0]  bit_q,   bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q,    tx_d;
   logic              last_baud;
   logic              last_bit;

   assign last_baud = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign last_bit  = (bit_q == BIT_W'(FRAME_BITS - 1));

   // The line value for the next bit is registered at each bit boundary.
   always_comb begin
      busy_d  = busy_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      if (load) begin
         busy_d  = 1'b1;
         baud_d  = '0;
         bit_d   = '0;
         shift_d = byte_in;
         tx_d    = START_BIT;
      end else if (busy_q) begin
         if (last_baud) begin
            baud_d = '0;
            if (last_bit) begin
               busy_d = 1'b0;
               bit_d  = '0;
               tx_d   = STOP_BIT;
            end else begin
               bit_d = bit_q + BIT_W'(1);
               if (bit_q == BIT_W'(FRAME_BITS - 2)) begin
                  tx_d = STOP_BIT;
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end else begin
            baud_d = baud_q + BAUD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= STOP_BIT;
      end else begin
         busy_q  <= busy_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = busy_q && last_baud && last_bit;

endmodule

// File: rtl/uart_music_tx.sv
// Dumps the note table over UART, one byte per note, followed by a terminator byte.
module uart_music_tx
   import uart_music_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 1250,
   parameter int unsigned NUM_NOTES    = 83,
   parameter int unsigned NOTE_W       = 5,
   parameter logic [7:0]  TERM_BYTE    = TERM_BYTE_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [7:0]        mem_addr,
   output logic              mem_rd_en,
   input  logic [NOTE_W-1:0] mem_data,
   output logic              uart_tx,
   output logic              busy,
   output logic              done
);

   state_e     state_q,    state_d;
   logic [7:0] addr_q,     addr_d;
   logic       rd_en_q,    rd_en_d;
   logic       busy_q,     busy_d;
   logic       done_q,     done_d;
   logic [1:0] term_ph_q,  term_ph_d;

   logic       load_c;
   logic [7:0] byte_c;
   logic       tx_done;
   logic       tx_busy;
   logic       last_note;

   assign last_note = (addr_q == 8'(NUM_NOTES - 1));

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_c),
      .byte_in (byte_c),
      .tx      (uart_tx),
      .tx_done (tx_done),
      .tx_busy (tx_busy)
   );

   // TERM holds the line high for two cycles before loading, matching the RD/WAIT gap.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rd_en_d   = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      term_ph_d = term_ph_q;
      load_c    = 1'b0;
      byte_c    = 8'(mem_data);
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = '0;
               rd_en_d = 1'b1;
               busy_d  = 1'b1;
               state_d = RD;
            end
         end
         RD: begin
            state_d = WAIT;
         end
         WAIT: begin
            load_c  = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (tx_done) begin
               if (last_note) begin
                  term_ph_d = 2'd0;
                  state_d   = TERM;
               end else begin
                  addr_d  = addr_q + 8'd1;
                  rd_en_d = 1'b1;
                  state_d = RD;
               end
            end
         end
         TERM: begin
            case (term_ph_q)
               2'd0: term_ph_d = 2'd1;
               2'd1: begin
                  if (!tx_busy) begin
                     load_c    = 1'b1;
                     byte_c    = TERM_BYTE;
                     term_ph_d = 2'd2;
                  end
               end
               default: begin
                  if (tx_done) begin
                     term_ph_d = 2'd0;
                     done_d    = 1'b1;
                     state_d   = FIN;
                  end
               end
            endcase
         end
         FIN: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         term_ph_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         term_ph_q <= term_ph_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_rd_en = rd_en_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_uart_music_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a line monitor decodes frames and checks them.
module tb_uart_music_tx;

   localparam int unsigned CPB       = 10;
   localparam int unsigned NN        = 3;
   localparam int unsigned NW        = 5;
   localparam int          FRAME_CYC = 10 * CPB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    mem_addr;
   logic          mem_rd_en;
   logic [NW-1:0] mem_data;
   logic          uart_tx, busy, done;

   logic [NW-1:0] ram [0:255];
   logic [7:0]    exp_q [$];
   int total = 0, bad = 0, cyc = 0;
   int frames_seen = 0, dones_seen = 0, reads_seen = 0, dump_t0 = 0;

   uart_music_tx #(
      .CLKS_PER_BIT (CPB),
      .NUM_NOTES    (NN),
      .NOTE_W       (NW),
      .TERM_BYTE    (8'd66)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_data  (mem_data),
      .uart_tx   (uart_tx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (mem_rd_en) mem_data <= ram[mem_addr];

   function automatic void chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Line monitor: rebuilds every frame from its samples and compares with the scoreboard.
   initial begin
      int p, fr_in_dump, high_run, done_due, b, ok;
      bit in_frame;
      logic s_arr [FRAME_CYC];
      logic [7:0] eb, ab;
      logic ev;
      p = 0; fr_in_dump = 0; high_run = 0; done_due = -1; in_frame = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_frame = 0; fr_in_dump = 0; high_run = 0; done_due = -1;
            continue;
         end
         if (mem_rd_en) begin
            reads_seen++;
            chk("rd_addr_bound", int'(mem_addr < 8'(NN)), 1);
         end
         if (done || cyc == done_due) begin
            chk("done_timing", int'(done && cyc == done_due), 1);
            if (done) begin
               dones_seen++;
               chk("dump_length", cyc - dump_t0, NN * (FRAME_CYC + 2) + FRAME_CYC);
            end
         end
         if (!in_frame) begin
            if (uart_tx == 1'b0) begin
               in_frame = 1; s_arr[0] = 1'b0; p = 1;
               if (fr_in_dump > 0) chk("gap_cycles", high_run, 2);
               else dump_t0 = cyc;
            end else begin
               high_run++;
            end
         end else begin
            s_arr[p] = uart_tx;
            if (p == FRAME_CYC - 1) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", 1, 0);
               end else begin
                  eb = exp_q.pop_front();
                  ok = 1;
                  for (int k = 0; k < 8; k++) ab[k] = s_arr[(k + 1) * CPB + CPB / 2];
                  for (int q = 0; q < FRAME_CYC; q++) begin
                     b = q / CPB;
                     ev = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b - 1];
                     if (s_arr[q] !== ev) ok = 0;
                  end
                  chk("frame_byte", int'(ab), int'(eb));
                  chk("frame_shape", ok, 1);
               end
               in_frame = 0; high_run = 0; frames_seen++; fr_in_dump++;
               if (fr_in_dump == NN + 1) begin
                  fr_in_dump = 0;
                  done_due = cyc + 1;
               end
            end else begin
               p++;
            end
         end
      end
   end

   task automatic push_dump();
      for (int i = 0; i < NN; i++) exp_q.push_back(8'(ram[i]));
      exp_q.push_back(8'h42);
   endtask

   task automatic fill_random();
      for (int i = 0; i < NN; i++) ram[i] = NW'($urandom_range(0, 31));
   endtask

   task automatic pulse_start(input int len);
      start = 1'b1;
      repeat (len) @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int f0, d0, r0, t, n, idle_bad;
      ram[0] = 5'd1; ram[1] = 5'd17; ram[2] = 5'd31;

      // Reset and quiet idle
      repeat (3) @(negedge clk);
      chk("rst_tx", int'(uart_tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_addr", int'(mem_addr), 0);
      chk("rst_rd_en", int'(mem_rd_en), 0);
      rst_n = 1'b1;
      r0 = reads_seen; idle_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_bad++;
      end
      chk("idle_quiet", idle_bad, 0);
      chk("idle_no_reads", reads_seen - r0, 0);

      // Single dump with the fixed table
      push_dump();
      f0 = frames_seen; d0 = dones_seen; t = cyc;
      pulse_start(1);
      chk("busy_after_start", int'(busy), 1);
      chk("first_rd_en", int'(mem_rd_en), 1);
      chk("first_addr", int'(mem_addr), 0);
      n = 0;
      while (uart_tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
      chk("start_latency", cyc - t, 3);
      wait_done(2000);
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      chk("frames_single", frames_seen - f0, NN + 1);
      chk("dones_single", dones_seen - d0, 1);

      // Start pulsed during the second frame is ignored
      fill_random(); push_dump();
      f0 = frames_seen; d0 = dones_seen; r0 = reads_seen; t = cyc;
      pulse_start(1);
      while (cyc < t + 3 + FRAME_CYC + 2 + 30) @(negedge clk);
      pulse_start(1);
      wait_done(2000);
      repeat (50) @(negedge clk);
      chk("frames_ignored", frames_seen - f0, NN + 1);
      chk("dones_ignored", dones_seen - d0, 1);
      chk("reads_ignored", reads_seen - r0, NN);

      // Start held high: back-to-back dumps
      fill_random(); push_dump(); push_dump();
      f0 = frames_seen; d0 = dones_seen;
      start = 1'b1;
      wait_done(2000);
      repeat (2) @(negedge clk);
      chk("retrig_rd_en", int'(mem_rd_en), 1);
      chk("retrig_addr", int'(mem_addr), 0);
      start = 1'b0;
      wait_done(2000);
      @(negedge clk);
      chk("frames_retrig", frames_seen - f0, 2 * (NN + 1));
      chk("dones_retrig", dones_seen - d0, 2);

      // Reset during bit 4 of the second frame, then restart
      fill_random(); push_dump();
      t = cyc;
      pulse_start(1);
      while (cyc < t + 3 + FRAME_CYC + 2 + 44) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_tx", int'(uart_tx), 1);
      chk("midrst_busy", int'(busy), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fill_random(); push_dump();
      f0 = frames_seen;
      pulse_start(1);
      chk("restart_addr", int'(mem_addr), 0);
      chk("restart_rd_en", int'(mem_rd_en), 1);
      wait_done(2000);
      @(negedge clk);
      chk("frames_restart", frames_seen - f0, NN + 1);

      // Randomised dumps with random idle and start widths
      repeat (2) begin
         fill_random(); push_dump();
         repeat ($urandom_range(1, 20)) @(negedge clk);
         f0 = frames_seen;
         pulse_start(int'($urandom_range(1, 3)));
         wait_done(2000);
         @(negedge clk);
         chk("frames_random", frames_seen - f0, NN + 1);
      end
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
